time_display_scan: RTL

- Reads the six BCD time digits produced by the keypad time-entry path (hour/min/sec, tens and ones) and drives a 6-digit multiplexed 7-segment display.
- Scans one digit at a time at a programmable rate.
- Takes a frame-consistent snapshot of the digits so a half-entered value never tears mid-frame.
- Blinks the field currently being edited.

---
 rtl/time_display_scan.sv | 120 ++++++++++++
 1 files changed

// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the BCD time-entry path.
// Optional LEADING_ZERO_BLANK_EN blanks a leading zero in the hour tens digit.
module time_display_scan #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_ten_in,
    input  logic [3:0] hour_one_in,
    input  logic [3:0] min_ten_in,
    input  logic [3:0] min_one_in,
    input  logic [3:0] sec_ten_in,
    input  logic [3:0] sec_one_in,
    input  logic [1:0] edit_field,
    output logic [7:0] seg_data,
    output logic [5:0] seg_com,
    output logic       frame_tick
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned IDX_W = 3;

    logic [DIV_W-1:0]  div_q;
    logic [IDX_W-1:0]  idx_q;
    logic [5:0][3:0]   snap_q;
    logic [1:0]        snap_field_q;
    logic [FRM_W-1:0]  frame_q;
    logic              blink_q;

    logic              div_done_c;
    logic              frame_done_c;
    logic [3:0]        digit_c;
    logic [1:0]        idx_field_c;
    logic              blank_c;
    logic [7:0]        seg_data_c;
    logic [5:0]        seg_com_c;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h27;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign div_done_c   = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_done_c = div_done_c && (idx_q == IDX_W'(5));

    // Segment pattern for the digit currently selected by idx_q.
    always_comb begin
        digit_c     = snap_q[0];
        seg_data_c  = 8'h00;
        idx_field_c = 2'(idx_q[2:1]) + 2'd1;
        case (idx_q)
            3'd1:    digit_c = snap_q[1];
            3'd2:    digit_c = snap_q[2];
            3'd3:    digit_c = snap_q[3];
            3'd4:    digit_c = snap_q[4];
            3'd5:    digit_c = snap_q[5];
            default: digit_c = snap_q[0];
        endcase
        blank_c = blink_q && (snap_field_q != 2'd0) && (snap_field_q == idx_field_c);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == IDX_W'(0) && digit_c == 4'd0) begin
            blank_c = 1'b1;
        end
`endif
        seg_data_c[6:0] = blank_c ? 7'h00 : seg_decode(digit_c);
        // Colon dots are never blinked.
        seg_data_c[7]   = (idx_q == IDX_W'(1)) || (idx_q == IDX_W'(3));
        seg_com_c       = ~(6'b00_0001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            snap_field_q <= 2'd0;
            frame_q      <= '0;
            blink_q      <= 1'b0;
            seg_com      <= 6'b11_1111;
            seg_data     <= 8'h00;
            frame_tick   <= 1'b0;
        end else begin
            div_q      <= div_done_c ? '0 : div_q + DIV_W'(1);
            frame_tick <= frame_done_c;
            seg_com    <= seg_com_c;
            seg_data   <= seg_data_c;
            if (div_done_c) begin
                idx_q <= frame_done_c ? '0 : idx_q + IDX_W'(1);
            end
            // Snapshot at the frame boundary so a frame never tears.
            if (frame_done_c) begin
                snap_q       <= {sec_one_in, sec_ten_in, min_one_in,
                                 min_ten_in, hour_one_in, hour_ten_in};
                snap_field_q <= edit_field;
                if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_q <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    frame_q <= frame_q + FRM_W'(1);
                end
            end
        end
    end

endmodule
